// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants, FSM states and digit decode helpers for the seven-segment scanner
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 2;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BLANK = 2'b01,
    DRIVE = 2'b10
  } scan_state_e;

  // Active-low one-hot anode for a digit; a masked digit stays dark.
  function automatic logic [NUM_DIGITS-1:0] digit_anode(input logic [DIGIT_W-1:0] digit,
                                                        input logic [NUM_DIGITS-1:0] mask);
    return mask[digit] ? ~(NUM_DIGITS'(1) << digit) : ANODE_OFF;
  endfunction

  function automatic logic digit_dp(input logic [DIGIT_W-1:0] digit,
                                    input logic [NUM_DIGITS-1:0] mask,
                                    input logic [NUM_DIGITS-1:0] dot);
    return mask[digit] ? ~dot[digit] : 1'b1;
  endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// rtl/seg_scan_controller_if.sv - control inputs and display-side outputs of the scan controller
interface seg_scan_if;
  import seven_seg_pkg::*;

  logic                  ENABLE;
  logic [NUM_DIGITS-1:0] DIGIT_MASK;
  logic [NUM_DIGITS-1:0] DOT_IN;
  logic [DIGIT_W-1:0]    Selection_Signal;
  logic [NUM_DIGITS-1:0] ANODE;
  logic                  DP;
  logic                  FRAME_START;

  modport master (
    input  ENABLE, DIGIT_MASK, DOT_IN,
    output Selection_Signal, ANODE, DP, FRAME_START
  );

  modport slave (
    output ENABLE, DIGIT_MASK, DOT_IN,
    input  Selection_Signal, ANODE, DP, FRAME_START
  );
endinterface

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - down-counter timing the blank and drive phases of a digit slot
module seg_slot_timer #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic load_blank_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(TICK_DIV - BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_blank_i ? BLANK_LOAD : DRIVE_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with length-1, so zero marks the final cycle of the phase.
  assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - 4-digit seven-segment scan FSM driving mux select, anodes and decimal point
module seg_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  seg_scan_if.master bus
);

  if (BLANK_CYCLES < 2 || TICK_DIV <= BLANK_CYCLES + 1) begin : g_bad_params
    $error("seg_scan_controller: need BLANK_CYCLES >= 2 and TICK_DIV > BLANK_CYCLES + 1");
  end

  scan_state_e           state_q;
  logic [DIGIT_W-1:0]    sel_q;
  logic [NUM_DIGITS-1:0] anode_q;
  logic                  dp_q;
  logic                  frame_q;

  logic                  tmr_clr, tmr_load, tmr_load_blank, tmr_en, tmr_done;
  logic [DIGIT_W-1:0]    next_digit;

  assign next_digit = DIGIT_W'(sel_q + 1'b1);

  always_comb begin
    tmr_clr        = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_blank = 1'b0;
    tmr_en         = (state_q == BLANK) || (state_q == DRIVE);
    case (state_q)
      IDLE: begin
        if (bus.ENABLE) begin
          tmr_load       = 1'b1;
          tmr_load_blank = 1'b1;
        end
      end
      BLANK: begin
        if (!bus.ENABLE)  tmr_clr  = 1'b1;
        else if (tmr_done) tmr_load = 1'b1;
      end
      DRIVE: begin
        if (!bus.ENABLE) begin
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          tmr_load       = 1'b1;
          tmr_load_blank = 1'b1;
        end
      end
      default: tmr_clr = 1'b1;
    endcase
  end

  seg_slot_timer #(
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .clr_i       (tmr_clr),
    .load_i      (tmr_load),
    .load_blank_i(tmr_load_blank),
    .en_i        (tmr_en),
    .done_o      (tmr_done)
  );

  // Select moves at blank entry so the registered mux settles before anodes turn on.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
      anode_q <= ANODE_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      anode_q <= ANODE_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ENABLE) begin
            state_q <= BLANK;
            sel_q   <= '0;
            frame_q <= 1'b1;
          end
        end
        BLANK: begin
          if (!bus.ENABLE) begin
            state_q <= IDLE;
          end else if (tmr_done) begin
            state_q <= DRIVE;
            anode_q <= digit_anode(sel_q, bus.DIGIT_MASK);
            dp_q    <= digit_dp(sel_q, bus.DIGIT_MASK, bus.DOT_IN);
          end
        end
        DRIVE: begin
          if (!bus.ENABLE) begin
            state_q <= IDLE;
          end else if (tmr_done) begin
            state_q <= BLANK;
            sel_q   <= next_digit;
            frame_q <= (next_digit == '0);
          end else begin
            anode_q <= digit_anode(sel_q, bus.DIGIT_MASK);
            dp_q    <= digit_dp(sel_q, bus.DIGIT_MASK, bus.DOT_IN);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Selection_Signal = sel_q;
  assign bus.ANODE            = anode_q;
  assign bus.DP               = dp_q;
  assign bus.FRAME_START      = frame_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - scoreboard bench for seg_scan_controller with TICK_DIV=8, BLANK_CYCLES=2
module tb_seg_scan_controller;
  import seven_seg_pkg::*;

  localparam int TD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] anode;
    logic       dp;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   fs_cnt;
  exp_t sb_q[$];

  seg_scan_if bus();

  seg_scan_controller #(
    .TICK_DIV    (TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs t cycles after the FRAME_START cycle of a running scan.
  function automatic exp_t model_run(int t, logic [3:0] mask, logic [3:0] dot);
    exp_t e;
    int   ph;
    int   d;
    ph      = t % TD;
    d       = (t / TD) % 4;
    e.sel   = 2'(d);
    e.fs    = ((t % (4 * TD)) == 0);
    e.anode = 4'b1111;
    e.dp    = 1'b1;
    if (ph >= BC && mask[d]) begin
      e.anode[d] = 1'b0;
      e.dp       = ~dot[d];
    end
    return e;
  endfunction

  function automatic exp_t model_idle(logic [1:0] sel);
    exp_t e;
    e.sel   = sel;
    e.anode = 4'b1111;
    e.dp    = 1'b1;
    e.fs    = 1'b0;
    return e;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic cycle_check(string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".sel"},   {2'b00, bus.Selection_Signal}, {2'b00, e.sel});
    chk({tag, ".anode"}, bus.ANODE, e.anode);
    chk({tag, ".dp"},    {3'b000, bus.DP}, {3'b000, e.dp});
    chk({tag, ".fs"},    {3'b000, bus.FRAME_START}, {3'b000, e.fs});
    chk({tag, ".onehot"}, {3'b000, ($countones(~bus.ANODE) <= 1)}, 4'b0001);
  endtask

  task automatic run_model(string tag, int t0, int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(model_run(t0 + i, bus.DIGIT_MASK, bus.DOT_IN));
      cycle_check(tag);
      if (bus.FRAME_START) fs_cnt++;
    end
  endtask

  task automatic reset_cycle(string tag);
    rst = 1'b1;
    sb_q.push_back(model_idle(2'b00));
    cycle_check(tag);
  endtask

  initial begin
    rst            = 1'b1;
    bus.ENABLE     = 1'b1;
    bus.DIGIT_MASK = 4'b1111;
    bus.DOT_IN     = 4'b0000;

    // Reset held 3 cycles with ENABLE high, then start and run 100 cycles
    for (int i = 0; i < 3; i++) reset_cycle("reset");
    chk("reset.state", {2'b00, dut.state_q}, {2'b00, IDLE});
    rst    = 1'b0;
    fs_cnt = 0;
    run_model("run", 0, 100);
    chk("frame_count", 4'(fs_cnt), 4'd4);

    // Masking
    reset_cycle("mask_rst");
    bus.DIGIT_MASK = 4'b0101;
    rst            = 1'b0;
    run_model("mask", 0, 32);

    // Decimal point on digit 2
    reset_cycle("dot_rst");
    bus.DIGIT_MASK = 4'b1111;
    bus.DOT_IN     = 4'b0100;
    rst            = 1'b0;
    run_model("dot", 0, 32);

    // Enable drop at DRIVE cycle 3 of digit 2, then restart
    reset_cycle("en_rst");
    bus.DOT_IN = 4'b0000;
    rst        = 1'b0;
    run_model("en_pre", 0, 21);
    bus.ENABLE = 1'b0;
    sb_q.push_back(model_idle(2'b10));
    cycle_check("en_drop");
    sb_q.push_back(model_idle(2'b10));
    cycle_check("en_idle");
    bus.ENABLE = 1'b1;
    run_model("en_restart", 0, 10);

    // Reset during DRIVE of digit 3
    reset_cycle("mid_rst0");
    rst = 1'b0;
    run_model("mid_pre", 0, 28);
    reset_cycle("mid_reset");
    chk("mid_reset.state", {2'b00, dut.state_q}, {2'b00, IDLE});
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
